// File: rtl/unipolar_rz_receiver.sv
// Unipolar return-to-zero line receiver: measures each high pulse on a synchronised line,
// classifies it as a 0/1 bit, assembles MSB-first words and flags frame gaps and bad traffic.
module unipolar_rz_receiver #(
    parameter int unsigned DATA_WIDTH         = 24,
    parameter real         CLOCK_RATE         = 50.0e6,
    parameter real         BIT_THRESHOLD_TIME = 0.6e-6,
    parameter real         MIN_HIGH_TIME      = 0.1e-6,
    parameter real         MAX_HIGH_TIME      = 2.5e-6,
    parameter real         RESET_TIME         = 50.0e-6
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  line_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  frame_end_o,
    output logic                  error_o
);

    localparam int ThresholdCyc = int'(CLOCK_RATE * BIT_THRESHOLD_TIME);
    localparam int MinHighCyc   = int'(CLOCK_RATE * MIN_HIGH_TIME);
    localparam int MaxHighCyc   = int'(CLOCK_RATE * MAX_HIGH_TIME);
    localparam int ResetCyc     = int'(CLOCK_RATE * RESET_TIME);

    localparam int MaxAB  = (ThresholdCyc > MinHighCyc) ? ThresholdCyc : MinHighCyc;
    localparam int MaxCD  = (MaxHighCyc > ResetCyc) ? MaxHighCyc : ResetCyc;
    localparam int MaxCyc = (MaxAB > MaxCD) ? MaxAB : MaxCD;

    localparam int unsigned CntW = $clog2(MaxCyc + 1);
    localparam int unsigned IdxW = $clog2(DATA_WIDTH + 1);

    localparam logic [CntW-1:0] ThresholdCnt = CntW'(ThresholdCyc);
    localparam logic [CntW-1:0] MinHighCnt   = CntW'(MinHighCyc);
    localparam logic [CntW-1:0] MaxHighCnt   = CntW'(MaxHighCyc);
    localparam logic [CntW-1:0] ResetCnt     = CntW'(ResetCyc);
    localparam logic [CntW-1:0] CntOne       = CntW'(1);
    localparam logic [IdxW-1:0] LastIdx      = IdxW'(DATA_WIDTH - 1);
    localparam logic [IdxW-1:0] IdxOne       = IdxW'(1);

    typedef enum logic [1:0] {StWaitGap, StIdle, StHigh, StLow} state_e;

    state_e                  state_q, state_d;
    logic [1:0]              sync_q;
    logic                    s_prev_q;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    frame_end_q, frame_end_d;
    logic                    error_q, error_d;

    logic s, rise, fall, bit_val, stuck, gap_done;

    assign s        = sync_q[1];
    assign rise     = s & ~s_prev_q;
    assign fall     = ~s & s_prev_q;
    assign bit_val  = (cnt_q >= ThresholdCnt);
    assign stuck    = s & (cnt_d >= MaxHighCnt);
    assign gap_done = ~s & (cnt_d >= ResetCnt);

    // Level-duration counter: cnt_d is the number of cycles s has held its current level.
    always_comb begin
        cnt_d = cnt_q;
        if (rise || fall) begin
            cnt_d = CntOne;
        end else if (cnt_q != {CntW{1'b1}}) begin
            cnt_d = cnt_q + CntOne;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            sync_q   <= '0;
            s_prev_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= {sync_q[0], line_i};
            s_prev_q <= sync_q[1];
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StWaitGap;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StWaitGap: if (gap_done) state_d = StIdle;
            StIdle:    if (rise) state_d = StHigh;
            StHigh: begin
                if (stuck) begin
                    state_d = StWaitGap;
                end else if (fall) begin
                    state_d = (cnt_q < MinHighCnt) ? StWaitGap : StLow;
                end
            end
            StLow: begin
                if (rise) begin
                    state_d = StHigh;
                end else if (gap_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StWaitGap;
        endcase
    end

    always_comb begin
        valid_d     = 1'b0;
        frame_end_d = 1'b0;
        error_d     = 1'b0;
        idx_d       = idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        unique case (state_q)
            StWaitGap: if (gap_done) idx_d = '0;
            StIdle: ;
            StHigh: begin
                if (stuck) begin
                    error_d = 1'b1;
                    idx_d   = '0;
                end else if (fall) begin
                    if (cnt_q < MinHighCnt) begin
                        error_d = 1'b1;
                        idx_d   = '0;
                    end else begin
                        shift_d = (shift_q << 1) | DATA_WIDTH'(bit_val);
                        if (idx_q == LastIdx) begin
                            data_d  = shift_d;
                            valid_d = 1'b1;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + IdxOne;
                        end
                    end
                end
            end
            StLow: begin
                // A gap ending a partial word is both a frame end and an error.
                if (!rise && gap_done) begin
                    frame_end_d = 1'b1;
                    error_d     = (idx_q != '0);
                    idx_d       = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            idx_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_end_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_end_q <= frame_end_d;
            error_q     <= error_d;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_end_o = frame_end_q;
    assign error_o     = error_q;

endmodule

// File: tb/tb_unipolar_rz_receiver.sv
// Bench for unipolar_rz_receiver: pulse-segment driver feeding a segment-level reference model
// that queues expected strobes; a monitor pops and compares each strobe the DUT produces.
module tb_unipolar_rz_receiver;

    localparam int THR  = 30;
    localparam int MINH = 5;
    localparam int MAXH = 125;
    localparam int RST  = 2500;

    localparam logic [2:0] K_VALID  = 3'b001;
    localparam logic [2:0] K_ERR    = 3'b010;
    localparam logic [2:0] K_FE     = 3'b100;
    localparam logic [2:0] K_FE_ERR = 3'b110;

    typedef struct {
        logic [2:0]  kind;
        logic [23:0] data;
        int          cyc;
    } ev_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        line;
    logic [23:0] data_o;
    logic        valid_o, frame_end_o, error_o;

    int  cyc = 0;
    int  n_vec = 0;
    int  n_bad = 0;
    ev_t exp_q[$];

    // Reference model state: 0 = waiting for gap, 1 = idle, 2 = inside a word.
    int          m_state;
    int          m_bits;
    int          m_low_run;
    int          m_low_start;
    logic [23:0] m_word;
    logic [23:0] m_last;

    int bw[4] = '{5, 29, 30, 124};

    unipolar_rz_receiver dut (
        .clock_i    (clock),
        .reset_i    (reset),
        .line_i     (line),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .frame_end_o(frame_end_o),
        .error_o    (error_o)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic push(input logic [2:0] kind, input logic [23:0] data, input int at);
        ev_t e;
        e.kind = kind;
        e.data = data;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        m_state     = 0;
        m_bits      = 0;
        m_low_run   = 0;
        m_low_start = cyc;
        m_word      = '0;
        m_last      = '0;
    endtask

    // Events are timed from the pin transition: 2 sync cycles plus 1 register cycle.
    task automatic model_high(input int k, input int len);
        m_low_run   = 0;
        m_low_start = k + len;
        if (m_state != 0) begin
            if (len >= MAXH) begin
                push(K_ERR, m_last, k + MAXH + 2);
                m_state = 0;
                m_bits  = 0;
            end else if (len < MINH) begin
                push(K_ERR, m_last, k + len + 3);
                m_state = 0;
                m_bits  = 0;
            end else begin
                m_word = {m_word[22:0], (len >= THR)};
                m_bits++;
                if (m_bits == 24) begin
                    m_last = m_word;
                    push(K_VALID, m_word, k + len + 3);
                    m_bits = 0;
                end
                m_state = 2;
            end
        end
    endtask

    task automatic model_low(input int len);
        m_low_run += len;
        if (m_low_run >= RST) begin
            if (m_state == 2) begin
                push((m_bits != 0) ? K_FE_ERR : K_FE, m_last, m_low_start + RST + 2);
                m_bits = 0;
            end
            if (m_state != 1) m_state = 1;
        end
    endtask

    task automatic seg(input logic lvl, input int len);
        if (lvl) model_high(cyc, len);
        else model_low(len);
        line = lvl;
        repeat (len) @(posedge clock);
        #1;
    endtask

    task automatic send_word(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) begin
            if (w[i]) begin seg(1'b1, 40); seg(1'b0, 22); end
            else begin seg(1'b1, 20); seg(1'b0, 42); end
        end
    endtask

    task automatic send_word_rand(input logic [23:0] w, input int glitch_at);
        for (int i = 23; i >= 0; i--) begin
            if (i == glitch_at) begin
                seg(1'b1, $urandom_range(MINH - 1, 1));
                seg(1'b0, $urandom_range(60, 1));
            end
            seg(1'b1, w[i] ? $urandom_range(MAXH - 1, THR) : $urandom_range(THR - 1, MINH));
            seg(1'b0, $urandom_range(60, 1));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        line  = 1'b0;
        #1;
        chk("reset_data", {8'h0, data_o}, 32'h0);
        chk("reset_valid", {31'h0, valid_o}, 32'h0);
        chk("reset_frame_end", {31'h0, frame_end_o}, 32'h0);
        chk("reset_error", {31'h0, error_o}, 32'h0);
        chk("queue_empty_at_reset", exp_q.size(), 32'h0);
        exp_q.delete();
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    always @(negedge clock) begin : monitor
        ev_t        e;
        logic [2:0] k;
        if (reset === 1'b0 && (valid_o || error_o || frame_end_o)) begin
            k = {frame_end_o, error_o, valid_o};
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected strobe: kind=%b data=%h cyc=%0d", k, data_o, cyc);
            end else begin
                e = exp_q.pop_front();
                if (k !== e.kind || data_o !== e.data || cyc != e.cyc) begin
                    n_bad++;
                    $display("FAIL strobe: got kind=%b data=%h cyc=%0d, expected kind=%b data=%h cyc=%0d",
                             k, data_o, cyc, e.kind, e.data, e.cyc);
                end
            end
        end
    end

    initial begin
        logic [23:0] w;
        reset = 1'b0;
        line  = 1'b0;
        #2;
        do_reset();

        // Basic word, then a frame gap.
        seg(1'b0, 2500);
        send_word(24'hA5C33C);
        seg(1'b0, 2600);

        // Back-to-back words; data must hold the second.
        send_word(24'h000001);
        send_word(24'hFFFFFE);
        seg(1'b0, 2600);
        chk("data_hold_after_b2b", {8'h0, data_o}, 32'h00FFFFFE);

        // Glitch, then recovery after a gap.
        seg(1'b1, 3);
        seg(1'b0, 2500);
        send_word(24'h123456);
        seg(1'b0, 2600);

        // Partial word ended by a gap.
        w = 24'($urandom);
        for (int i = 23; i >= 14; i--) begin
            seg(1'b1, w[i] ? 40 : 20);
            seg(1'b0, w[i] ? 22 : 42);
        end
        seg(1'b0, 2500);
        chk("data_kept_after_partial", {8'h0, data_o}, 32'h00123456);

        // Stuck-high line; a short low is not enough to resynchronise.
        seg(1'b1, 300);
        seg(1'b0, 1000);
        send_word(24'($urandom));
        seg(1'b0, 2600);
        send_word(24'($urandom));
        seg(1'b0, 2600);

        // Width boundaries: 4 is a glitch, 125 is stuck, 5/29/30/124 are legal bits.
        seg(1'b1, 4);
        seg(1'b0, 2500);
        seg(1'b1, 125);
        seg(1'b0, 2500);
        for (int i = 0; i < 24; i++) begin
            seg(1'b1, bw[i % 4]);
            seg(1'b0, (i % 2 != 0) ? 60 : 1);
        end
        seg(1'b0, 2600);

        // Reset in the middle of bit 12.
        send_word(24'hC0FFEE);
        seg(1'b0, 2600);
        w = 24'($urandom);
        for (int i = 23; i >= 13; i--) begin
            seg(1'b1, w[i] ? 40 : 20);
            seg(1'b0, w[i] ? 22 : 42);
        end
        line = 1'b1;
        repeat (15) @(posedge clock);
        #3;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            seg(1'b1, 40);
            seg(1'b0, 22);
        end
        seg(1'b0, 2600);
        send_word(24'h5A5A01);
        seg(1'b0, 2600);

        // Randomised words, widths, glitches and gaps.
        for (int n = 0; n < 6; n++) begin
            send_word_rand(24'($urandom), ($urandom_range(3, 0) == 0) ? $urandom_range(23, 0) : -1);
            if ($urandom_range(1, 0) == 1) seg(1'b0, RST + $urandom_range(300, 0));
        end
        seg(1'b0, 2600);

        repeat (20) @(posedge clock);
        #1;
        chk("pending_events", exp_q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
